fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage with PC sequencing and an IF/ID pipeline register, upstream of the register file/control/ALU datapath. Drives a synchronous instruction memory with a one-cycle read latency. Presents each fetched instruction and its PC+4 to decode. Handles decode stalls, and handles branch and jump redirects by flushing the wrong-path instruction.

## Interface

**Parameters**
- `PC_RESET`, default 32'h0000_0000: address of the first instruction fetched after reset; must be word-aligned.

**Ports**
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `stall` in 1: decode cannot accept; hold PC and IF/ID contents.
- `branch_taken` in 1: taken branch resolved this cycle.
- `branch_base` in 32: PC+4 of the branch instruction.
- `branch_offset` in 32: sign-extended 16-bit immediate.
- `jump` in 1: jump decoded this cycle.
- `jump_base` in 32: PC+4 of the jump instruction.
- `jump_index` in 26: instruction[25:0] of the jump.
- `imem_addr` out 32: instruction memory read address; sampled by the memory at the clock edge.
- `imem_rdata` in 32: memory data for the address sampled at the previous edge.
- `id_instr` out 32: instruction in IF/ID.
- `id_pc_plus4` out 32: PC+4 of `id_instr`.
- `id_valid` out 1: `id_instr` is a real instruction, not a bubble.
- `fetch_count` out 32: number of valid instructions loaded into IF/ID.

## Operation

**Internal state**
- `state` ∈ {BOOT, RUN}.
- `pc`: address whose data is on `imem_rdata` this cycle.
- IF/ID registers.
- `fetch_count`.

**Targets (32-bit, wrapping arithmetic)**
- Branch target: `branch_base + (branch_offset << 2)`.
- Jump target: `{jump_base[31:28], jump_index, 2'b00}`.
- `redirect = branch_taken | jump`.
- Priority when both are asserted: branch wins (the older instruction).

**BOOT (entered on reset)**
- `imem_addr = PC_RESET`.
- `stall`, `branch_taken` and `jump` are ignored.
- IF/ID holds its bubble.
- Next edge: `pc <= PC_RESET`, go to RUN.

**RUN, `imem_addr = pc_next` (combinational), in priority order**
- `redirect`: `pc_next` = target.
  - IF/ID loads a bubble: `id_instr <= 0`, `id_valid <= 0`, `id_pc_plus4 <= 0`.
  - The instruction currently on `imem_rdata` is discarded.
  - Redirect overrides `stall`.
- `stall`: `pc_next = pc`, so the memory re-reads and `imem_rdata` is stable.
  - IF/ID and `fetch_count` hold.
- Otherwise: `pc_next = pc + 4`.
  - `id_instr <= imem_rdata`, `id_pc_plus4 <= pc + 4`, `id_valid <= 1`.
  - `fetch_count` increments.
- `pc <= pc_next` every RUN cycle.

**Wrap-around**
- `pc + 4` from 32'hFFFF_FFFC gives 0.
- `fetch_count` wraps from 32'hFFFF_FFFF to 0.

## Timing

**Reset values (asynchronous)**
- `state` = BOOT, `pc` = `PC_RESET`, `imem_addr` = `PC_RESET`.
- `id_instr` = 0, `id_pc_plus4` = 0, `id_valid` = 0, `fetch_count` = 0.

**Latency**
- First valid `id_valid` occurs 2 edges after reset deassertion: BOOT edge, then the load edge.
- In steady state, one instruction per cycle.

**Redirect**
- Redirect in cycle N: target address on `imem_addr` in cycle N; bubble in IF/ID after edge N.
- Target instruction appears in IF/ID after edge N+1.
- Penalty: exactly 1 bubble.

**Stall**
- Stall asserted for k cycles holds IF/ID for k cycles.
- No instruction is lost or duplicated.
- `fetch_count` counts each instruction once.

**Reset mid-operation**
- Immediately returns every output to its reset value, regardless of state.

**Signals outside RUN**
- `redirect` or `stall` asserted in BOOT: no effect.

## Test plan

- **Reset and streaming:** `PC_RESET` = 0x100, memory[a] = a, no stall → `imem_addr` 0x100,0x100,0x104,0x108,…; `id_instr` 0x100,0x104,… from edge 2; `id_pc_plus4` 0x104,0x108,…; `fetch_count` = 5 after 6 edges.
- **Stall:** stall for 3 cycles while `id_instr` = 0x108 → `id_instr` holds 0x108, `imem_addr` holds 0x10C; after release `id_instr` = 0x10C next edge; `fetch_count` unchanged during the stall.
- **Branch:** `branch_taken` with `branch_base` = 0x10C, `branch_offset` = 0xFFFF_FFFE → `imem_addr` = 0x104 that cycle; next `id_valid` = 0, `id_instr` = 0; following `id_instr` = 0x104.
- **Jump vs branch:**
  - `jump` with `jump_base` = 0x1000_0010, `jump_index` = 0x40 → target 0x1000_0100.
  - Same cycle with `branch_taken` (`branch_base` = 0x200, offset 1) → target 0x204 wins.
- **Redirect plus stall, and BOOT:** redirect with stall both high → bubble loaded and PC redirected. Redirect asserted during BOOT → ignored, first fetch at `PC_RESET`.
- **Wrap and async reset:**
  - `pc` = 0xFFFF_FFFC → next `imem_addr` = 0.
  - `reset` asserted mid-cycle while streaming → outputs zero and `imem_addr` = `PC_RESET` without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: decode-side stall/redirect controls, instruction memory port and IF/ID outputs.
// The fetch stage uses the master modport; the surrounding datapath/memory uses slave.
interface fetch_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump;
    logic [31:0] jump_base;
    logic [25:0] jump_index;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall, branch_taken, branch_base, branch_offset,
        input  jump, jump_base, jump_index, imem_rdata,
        output imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_base, branch_offset,
        output jump, jump_base, jump_index, imem_rdata,
        input  imem_addr, id_instr, id_pc_plus4, id_valid, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing against a 1-cycle synchronous imem, IF/ID register,
// stall hold and branch/jump redirect with a single-bubble flush.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    // Only the region bits of the jump's PC+4 participate in the target.
    logic unused_jump_base;
    assign unused_jump_base = ^bus.jump_base[27:0];

    function automatic logic [31:0] branch_target(input logic [31:0] base,
                                                  input logic [31:0] offset);
        logic signed [31:0] off_s;
        off_s = $signed(offset);
        return base + $unsigned(off_s <<< 2);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] base,
                                                input logic [25:0] index);
        return {base[31:28], index, 2'b00};
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d       = state_q;
        pc_next       = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                pc_next = PC_RESET;
            end
            RUN: begin
                // Branch beats jump: it belongs to the older instruction.
                if (bus.branch_taken || bus.jump) begin
                    pc_next       = bus.branch_taken
                                  ? branch_target(bus.branch_base, bus.branch_offset)
                                  : jump_target(bus.jump_base, bus.jump_index);
                    id_instr_d    = 32'd0;
                    id_pc_plus4_d = 32'd0;
                    id_valid_d    = 1'b0;
                end else if (bus.stall) begin
                    pc_next = pc_q;
                end else begin
                    pc_next       = pc_plus4;
                    id_instr_d    = bus.imem_rdata;
                    id_pc_plus4_d = pc_plus4;
                    id_valid_d    = 1'b1;
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            default: begin
                state_d = BOOT;
                pc_next = PC_RESET;
            end
        endcase

        pc_d = pc_next;
    end

    // imem samples pc_next at the same edge pc_q loads it, so pc_q tracks imem_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= PC_RESET;
            id_instr_q    <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.imem_addr   = pc_next;
    assign bus.id_instr    = id_instr_q;
    assign bus.id_pc_plus4 = id_pc_plus4_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model feeds a scoreboard queue that each
// scenario task pops and compares after every clock edge.
module tb_fetch_stage;
    localparam logic [31:0] PC_RST = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.PC_RESET(PC_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous instruction memory whose content at address a is a.
    always @(posedge clk) bus.imem_rdata <= bus.imem_addr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    bit          m_boot;
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;
    logic [31:0] obs_addr;

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = PC_RST;
        m_instr = 32'd0;
        m_pc4   = 32'd0;
        m_valid = 1'b0;
        m_cnt   = 32'd0;
        sb.delete();
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_base   = 32'd0;
        bus.branch_offset = 32'd0;
        bus.jump          = 1'b0;
        bus.jump_base     = 32'd0;
        bus.jump_index    = 26'd0;
    endtask

    // Drive one cycle of controls, push the model's expectation, sample imem_addr, clock once.
    task automatic tick(input logic st, input logic br, input logic [31:0] bb,
                        input logic [31:0] bo, input logic jp, input logic [31:0] jb,
                        input logic [25:0] ji);
        exp_t        e;
        logic [31:0] t;
        bus.stall = st; bus.branch_taken = br; bus.branch_base = bb; bus.branch_offset = bo;
        bus.jump = jp; bus.jump_base = jb; bus.jump_index = ji;
        if (m_boot) begin
            t = PC_RST;
            m_boot = 1'b0;
        end else if (br || jp) begin
            if (br) t = bb + {bo[29:0], 2'b00};
            else    t = {jb[31:28], ji, 2'b00};
            m_instr = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
        end else if (st) begin
            t = m_pc;
        end else begin
            t = m_pc + 32'd4;
            m_instr = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
        end
        m_pc    = t;
        e.addr  = t;
        e.instr = m_instr;
        e.pc4   = m_pc4;
        e.valid = m_valid;
        e.cnt   = m_cnt;
        sb.push_back(e);
        #2 obs_addr = bus.imem_addr;
        @(posedge clk);
        #1 idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_reset();
        #3;
        n_vec++;
        if ({bus.imem_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
            {PC_RST, 32'd0, 32'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL reset_state: addr=%h instr=%h pc4=%h v=%b cnt=%0d required addr=%h and zeros",
                     bus.imem_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count, PC_RST);
        end
        @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic test_boot_redirect();
        exp_t e;
        tick(1'b1, 1'b1, 32'h0000_0500, 32'd4, 1'b1, 32'h2000_0000, 26'h123);
        e = sb.pop_front();
        n_vec++;
        if ({obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
            {e.addr, e.instr, e.pc4, e.valid, e.cnt} || obs_addr !== PC_RST) begin
            n_err++;
            $display("FAIL boot_ignore: addr=%h instr=%h v=%b required addr=%h instr=%h v=%b",
                     obs_addr, bus.id_instr, bus.id_valid, PC_RST, e.instr, e.valid);
        end
    endtask

    task automatic test_stream();
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
            e = sb.pop_front();
            n_vec++;
            if ({obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
                {e.addr, e.instr, e.pc4, e.valid, e.cnt}) begin
                n_err++;
                $display("FAIL stream[%0d]: addr=%h instr=%h pc4=%h v=%b cnt=%0d required addr=%h instr=%h pc4=%h v=%b cnt=%0d",
                         i, obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count,
                         e.addr, e.instr, e.pc4, e.valid, e.cnt);
            end
        end
        n_vec++;
        if (bus.fetch_count !== 32'd5 || bus.id_instr !== 32'h110) begin
            n_err++;
            $display("FAIL stream_count: cnt=%0d instr=%h required cnt=5 instr=00000110",
                     bus.fetch_count, bus.id_instr);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
            e = sb.pop_front();
            n_vec++;
            if ({obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
                {e.addr, e.instr, e.pc4, e.valid, e.cnt} || bus.fetch_count !== 32'd5) begin
                n_err++;
                $display("FAIL stall[%0d]: addr=%h instr=%h cnt=%0d required addr=%h instr=%h cnt=%0d",
                         i, obs_addr, bus.id_instr, bus.fetch_count, e.addr, e.instr, e.cnt);
            end
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({bus.id_instr, bus.id_valid, bus.fetch_count} !== {32'h114, 1'b1, 32'd6} ||
            bus.id_instr !== e.instr) begin
            n_err++;
            $display("FAIL stall_release: instr=%h cnt=%0d required instr=00000114 cnt=6",
                     bus.id_instr, bus.fetch_count);
        end
    endtask

    task automatic test_branch();
        exp_t e;
        tick(1'b0, 1'b1, 32'h0000_010C, 32'hFFFF_FFFE, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_addr, bus.id_instr, bus.id_valid, bus.id_pc_plus4} !== {32'h104, 32'd0, 1'b0, 32'd0} ||
            e.addr !== obs_addr) begin
            n_err++;
            $display("FAIL branch_bubble: addr=%h instr=%h v=%b required addr=00000104 instr=0 v=0",
                     obs_addr, bus.id_instr, bus.id_valid);
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
            {e.instr, e.pc4, e.valid, e.cnt} || bus.id_instr !== 32'h104) begin
            n_err++;
            $display("FAIL branch_target: instr=%h pc4=%h cnt=%0d required instr=%h pc4=%h cnt=%0d",
                     bus.id_instr, bus.id_pc_plus4, bus.fetch_count, e.instr, e.pc4, e.cnt);
        end
    endtask

    task automatic test_jump_vs_branch();
        exp_t e;
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h1000_0010, 26'h40);
        e = sb.pop_front();
        n_vec++;
        if (obs_addr !== 32'h1000_0100 || bus.id_valid !== e.valid) begin
            n_err++;
            $display("FAIL jump_target: addr=%h v=%b required addr=10000100 v=0", obs_addr, bus.id_valid);
        end
        tick(1'b0, 1'b1, 32'h0000_0200, 32'd1, 1'b1, 32'h1000_0010, 26'h40);
        e = sb.pop_front();
        n_vec++;
        if (obs_addr !== 32'h204 || e.addr !== 32'h204 || bus.id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL branch_priority: addr=%h v=%b required addr=00000204 v=0", obs_addr, bus.id_valid);
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({bus.id_instr, bus.id_pc_plus4, bus.id_valid} !== {32'h204, 32'h208, 1'b1} ||
            bus.fetch_count !== e.cnt) begin
            n_err++;
            $display("FAIL priority_fetch: instr=%h pc4=%h cnt=%0d required instr=00000204 pc4=00000208 cnt=%0d",
                     bus.id_instr, bus.id_pc_plus4, bus.fetch_count, e.cnt);
        end
    endtask

    task automatic test_redirect_stall();
        exp_t e;
        tick(1'b1, 1'b1, 32'h0000_0300, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_addr, bus.id_instr, bus.id_valid} !== {32'h300, 32'd0, 1'b0} ||
            bus.fetch_count !== e.cnt) begin
            n_err++;
            $display("FAIL redirect_over_stall: addr=%h instr=%h v=%b required addr=00000300 instr=0 v=0",
                     obs_addr, bus.id_instr, bus.id_valid);
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({bus.id_instr, bus.id_valid} !== {32'h300, 1'b1} || bus.id_instr !== e.instr) begin
            n_err++;
            $display("FAIL redirect_stall_fetch: instr=%h v=%b required instr=00000300 v=1",
                     bus.id_instr, bus.id_valid);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hF000_0000, 26'h3FF_FFFF);
        e = sb.pop_front();
        n_vec++;
        if (obs_addr !== 32'hFFFF_FFFC || e.addr !== obs_addr) begin
            n_err++;
            $display("FAIL wrap_jump: addr=%h required addr=fffffffc", obs_addr);
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid} !==
            {32'd0, 32'hFFFF_FFFC, 32'd0, 1'b1} || bus.fetch_count !== e.cnt) begin
            n_err++;
            $display("FAIL wrap_pc: addr=%h instr=%h pc4=%h v=%b required addr=0 instr=fffffffc pc4=0 v=1",
                     obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid);
        end
        tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_addr, bus.id_instr, bus.id_pc_plus4} !== {e.addr, e.instr, e.pc4} ||
            bus.id_pc_plus4 !== 32'd4) begin
            n_err++;
            $display("FAIL wrap_next: addr=%h instr=%h pc4=%h required addr=%h instr=%h pc4=%h",
                     obs_addr, bus.id_instr, bus.id_pc_plus4, e.addr, e.instr, e.pc4);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
            void'(sb.pop_front());
        end
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({bus.imem_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
            {PC_RST, 32'd0, 32'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL async_reset: addr=%h instr=%h pc4=%h v=%b cnt=%0d required addr=%h and zeros",
                     bus.imem_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count, PC_RST);
        end
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 26'd0);
            e = sb.pop_front();
            n_vec++;
            if ({obs_addr, bus.id_instr, bus.id_pc_plus4, bus.id_valid, bus.fetch_count} !==
                {e.addr, e.instr, e.pc4, e.valid, e.cnt}) begin
                n_err++;
                $display("FAIL post_reset[%0d]: addr=%h instr=%h v=%b cnt=%0d required addr=%h instr=%h v=%b cnt=%0d",
                         i, obs_addr, bus.id_instr, bus.id_valid, bus.fetch_count,
                         e.addr, e.instr, e.valid, e.cnt);
            end
        end
        n_vec++;
        if ({bus.id_instr, bus.fetch_count} !== {32'h100, 32'd1}) begin
            n_err++;
            $display("FAIL post_reset_first: instr=%h cnt=%0d required instr=00000100 cnt=1",
                     bus.id_instr, bus.fetch_count);
        end
    endtask

    initial begin
        test_reset();
        test_boot_redirect();
        test_stream();
        test_stall();
        test_branch();
        test_jump_vs_branch();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
